// File: rtl/ntt_pkg.sv
// Shared constants, FSM states and modular-arithmetic helpers for the inverse NTT.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ntt_pkg;

  // The constants below describe the default sizing of the transform.
  localparam int unsigned NTT_N        = 256;
  localparam int unsigned NTT_Q        = 8380417;
  localparam int unsigned NTT_PARALLEL = 8;
  localparam int unsigned ZETA_ROOT    = 1753;  // primitive 512th root of unity mod Q

  localparam int unsigned LOGN          = $clog2(NTT_N);
  localparam int unsigned CYC_PER_STAGE = (NTT_N / 2) / NTT_PARALLEL;
  localparam int unsigned SCALE_CYCLES  = NTT_N / (2 * NTT_PARALLEL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGE  = 2'd1,
    SCALE  = 2'd2,
    FINISH = 2'd3
  } ntt_state_t;

  // Modular product; operands are below 2^32 so the 64-bit product is exact.
  function automatic logic [63:0] mod_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] m);
    return (a * b) % m;
  endfunction

  // Square-and-multiply exponentiation, used only for elaboration-time constants.
  function automatic logic [63:0] pow_mod(input logic [63:0] base, input logic [63:0] ex,
                                          input logic [63:0] m);
    logic [63:0] r;
    logic [63:0] x;
    logic [63:0] e;
    r = 64'd1;
    x = base % m;
    e = ex;
    while (e != 64'd0) begin
      if (e[0]) r = mod_mul(r, x, m);
      x = mod_mul(x, x, m);
      e = e >> 1;
    end
    return r;
  endfunction

  // Reverse the low 'bits' bits of x.
  function automatic logic [63:0] bit_rev(input logic [63:0] x, input int unsigned bits);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < bits; i++) r[i] = x[bits-1-i];
    return r;
  endfunction

  // N^-1 mod Q via Fermat's little theorem (8347681 at the default sizing).
  localparam int unsigned NINV = 32'(pow_mod(64'(NTT_N), 64'(NTT_Q - 2), 64'(NTT_Q)));

endpackage

// File: rtl/ntt_butterfly_gs.sv
// Gentleman-Sande butterfly: a' = a+b mod Q, b' = (b-a)*zeta mod Q, fully reduced.
// Latency: combinational.
// Backpressure: none.
module ntt_butterfly_gs #(
  parameter int WIDTH = 32,
  parameter int Q     = 8380417
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_zeta,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);
  import ntt_pkg::*;

  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] L_Q = W1'(Q);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrap;
  logic [WIDTH-1:0] w_diff;

  // Sum needs one spare bit; a single conditional subtract reduces it.
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign o_a   = (w_sum >= L_Q) ? WIDTH'(w_sum - L_Q) : WIDTH'(w_sum);

  // Add Q before subtracting when b < a so no intermediate goes negative.
  assign w_wrap = {1'b0, i_b} + L_Q - {1'b0, i_a};
  assign w_diff = (i_b >= i_a) ? (i_b - i_a) : WIDTH'(w_wrap);

  assign o_b = WIDTH'(mod_mul(64'(w_diff), 64'(i_zeta), 64'(Q)));

endmodule

// File: rtl/ntt_inverse.sv
// Inverse negacyclic NTT (GS, bit-reversed in, natural out) done in place on a flop array.
// Latency: LOGN*CYC_PER_STAGE + SCALE_CYCLES busy cycles (144 at defaults), then one done cycle.
// Backpressure: none; start and loads are ignored while busy, read_data is registered one cycle.
module ntt_inverse #(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int Q          = 8380417,
  parameter int ADDR_WIDTH = 8,
  parameter int PARALLEL   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  input  logic                  load_coeff,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]      load_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);
  import ntt_pkg::*;

  ntt_state_t            r_state;
  ntt_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_stage;
  logic [ADDR_WIDTH-1:0] r_cyc;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_stage_end;
  logic                  w_last_stage;
  logic                  w_scale_end;

  logic [WIDTH-1:0]      r_coef [N];
  logic [WIDTH-1:0]      r_read_data;
  logic [WIDTH-1:0]      w_zeta_rom [N];

  logic [ADDR_WIDTH-1:0] w_lo_idx [PARALLEL];
  logic [ADDR_WIDTH-1:0] w_hi_idx [PARALLEL];
  logic [WIDTH-1:0]      w_a_new  [PARALLEL];
  logic [WIDTH-1:0]      w_b_new  [PARALLEL];
  logic [ADDR_WIDTH-1:0] w_sc_idx [2*PARALLEL];
  logic [WIDTH-1:0]      w_sc_val [2*PARALLEL];

  assign w_stage_end  = (r_cyc == ADDR_WIDTH'(CYC_PER_STAGE - 1));
  assign w_last_stage = (r_stage == ADDR_WIDTH'(LOGN - 1));
  assign w_scale_end  = (r_cyc == ADDR_WIDTH'(SCALE_CYCLES - 1));

  // Twiddle ROM: entry k holds ROOT^brv(k) mod Q, folded to constants at elaboration.
  for (genvar k = 0; k < N; k++) begin : g_zeta_rom
    localparam logic [WIDTH-1:0] L_ZETA =
      WIDTH'(pow_mod(64'(ZETA_ROOT), bit_rev(64'(k), ADDR_WIDTH), 64'(Q)));
    assign w_zeta_rom[k] = L_ZETA;
  end

  // Per lane: butterfly index -> group/offset -> pair (lo, lo+len); plus two scale slots.
  for (genvar p = 0; p < PARALLEL; p++) begin : g_lane
    logic [ADDR_WIDTH-1:0] w_bf;
    logic [ADDR_WIDTH-1:0] w_len;
    logic [ADDR_WIDTH-1:0] w_grp;
    logic [ADDR_WIDTH-1:0] w_lo;
    logic [ADDR_WIDTH-1:0] w_hi;
    logic [ADDR_WIDTH-1:0] w_zidx;

    assign w_bf   = ADDR_WIDTH'(32'(r_cyc) * 32'(PARALLEL) + 32'(p));
    assign w_len  = ADDR_WIDTH'(1) << r_stage;
    assign w_grp  = w_bf >> r_stage;
    assign w_lo   = (w_grp << (r_stage + ADDR_WIDTH'(1))) | (w_bf & (w_len - ADDR_WIDTH'(1)));
    assign w_hi   = w_lo | w_len;
    // Groups walk the forward table downwards from its top end for each stage.
    assign w_zidx = ADDR_WIDTH'((32'(N) >> r_stage) - 32'd1 - 32'(w_grp));

    assign w_lo_idx[p] = w_lo;
    assign w_hi_idx[p] = w_hi;

    ntt_butterfly_gs #(.WIDTH(WIDTH), .Q(Q)) u_bfly (
      .i_a    (r_coef[w_lo]),
      .i_b    (r_coef[w_hi]),
      .i_zeta (w_zeta_rom[w_zidx]),
      .o_a    (w_a_new[p]),
      .o_b    (w_b_new[p])
    );

    for (genvar h = 0; h < 2; h++) begin : g_scale
      logic [ADDR_WIDTH-1:0] w_idx;
      assign w_idx = ADDR_WIDTH'(32'(r_cyc) * 32'(2 * PARALLEL) + 32'(2 * p + h));
      assign w_sc_idx[2*p+h] = w_idx;
      assign w_sc_val[2*p+h] = WIDTH'(mod_mul(64'(r_coef[w_idx]), 64'(NINV), 64'(Q)));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and status outputs; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE:   if (start) w_state_nxt = STAGE;
      STAGE: begin
        w_busy = 1'b1;
        if (w_stage_end && w_last_stage) w_state_nxt = SCALE;
      end
      SCALE: begin
        w_busy = 1'b1;
        if (w_scale_end) w_state_nxt = FINISH;
      end
      FINISH: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage and cycle counters; both sit at zero outside STAGE/SCALE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
      r_cyc   <= '0;
    end else begin
      unique case (r_state)
        STAGE: begin
          if (w_stage_end) begin
            r_cyc   <= '0;
            r_stage <= w_last_stage ? '0 : r_stage + ADDR_WIDTH'(1);
          end else begin
            r_cyc <= r_cyc + ADDR_WIDTH'(1);
          end
        end
        SCALE:   r_cyc <= w_scale_end ? '0 : r_cyc + ADDR_WIDTH'(1);
        default: begin
          r_stage <= '0;
          r_cyc   <= '0;
        end
      endcase
    end
  end

  // Coefficient store: host loads when idle, in-place butterfly/scale write-back when busy.
  always_ff @(posedge clk) begin
    if (!w_busy && load_coeff) r_coef[load_addr] <= load_data;
    if (r_state == STAGE) begin
      for (int p = 0; p < PARALLEL; p++) begin
        r_coef[w_lo_idx[p]] <= w_a_new[p];
        r_coef[w_hi_idx[p]] <= w_b_new[p];
      end
    end
    if (r_state == SCALE) begin
      for (int m = 0; m < 2 * PARALLEL; m++) r_coef[w_sc_idx[m]] <= w_sc_val[m];
    end
    r_read_data <= r_coef[read_addr];
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign read_data = r_read_data;

endmodule
